// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and state type for the LDW/SDW pair sequencer
package seq_pkg;

  localparam logic [5:0]  OP_LDW   = 6'b000110;
  localparam logic [5:0]  OP_SDW   = 6'b000111;
  localparam logic [13:0] IMM_STEP = 14'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } seq_state_e;

  function automatic logic is_pair_op(input logic [5:0] op);
    return (op == OP_LDW) || (op == OP_SDW);
  endfunction

endpackage

// File: rtl/ldw_sdw_sequencer.sv
// rtl/ldw_sdw_sequencer.sv - splits LDW/SDW into two micro-ops (rd/imm, rd+1/imm+4)
// Single ops pass straight through; paired ops hold fetch for one cycle.
module ldw_sdw_sequencer
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [5:0]  opcode,
  input  logic [3:0]  rd_in,
  input  logic [13:0] imm_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        uop_valid,
  output logic        uop_second,
  output logic [3:0]  rd_out,
  output logic [13:0] imm_out,
  output logic        fetch_hold,
  output logic        odd_rd_exc,
  output logic        imm_wrap
);

  seq_state_e  state;
  logic [3:0]  rd_lat;
  logic [13:0] imm_lat;
  logic        wrap_lat;
  logic        exc_done;

  logic        pair_op;
  logic        start_pair;
  logic        exc_fire;
  logic [14:0] imm_sum;

  assign pair_op    = instr_valid && is_pair_op(opcode);
  assign start_pair = (state == ST_IDLE) && pair_op && !rd_in[0];
  // exc_done suppresses a repeat pulse while an odd-rd pair sits stalled in decode
  assign exc_fire   = (state == ST_IDLE) && pair_op && rd_in[0] && !exc_done;
  assign imm_sum    = {1'b0, imm_in} + {1'b0, IMM_STEP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_lat   <= 4'd0;
      imm_lat  <= 14'd0;
      wrap_lat <= 1'b0;
      exc_done <= 1'b0;
    end else if (flush_in) begin
      state    <= ST_IDLE;
      exc_done <= 1'b0;
    end else if (stall_in) begin
      if (exc_fire) begin
        exc_done <= 1'b1;
      end
    end else begin
      exc_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start_pair) begin
          state    <= ST_SECOND;
          rd_lat   <= rd_in + 4'd1;
          imm_lat  <= imm_sum[13:0];
          wrap_lat <= imm_sum[14];
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Outputs are combinational so single ops see zero added latency; reset forces all to 0
  always_comb begin
    uop_valid  = 1'b0;
    uop_second = 1'b0;
    rd_out     = 4'd0;
    imm_out    = 14'd0;
    fetch_hold = 1'b0;
    odd_rd_exc = 1'b0;
    imm_wrap   = 1'b0;
    if (!reset) begin
      if (state == ST_SECOND) begin
        uop_valid  = !flush_in;
        uop_second = !flush_in;
        rd_out     = rd_lat;
        imm_out    = imm_lat;
        imm_wrap   = wrap_lat && !flush_in;
      end else begin
        rd_out  = rd_in;
        imm_out = imm_in;
        if (!flush_in) begin
          if (pair_op) begin
            uop_valid  = !rd_in[0];
            fetch_hold = !rd_in[0];
            odd_rd_exc = exc_fire;
          end else begin
            uop_valid = instr_valid;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ldw_sdw_sequencer.sv
// tb/tb_ldw_sdw_sequencer.sv - directed vector table plus randomized reference-model check
module tb_ldw_sdw_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [3:0]  rd_in;
  logic [13:0] imm_in;
  logic        stall_in;
  logic        flush_in;
  logic        uop_valid;
  logic        uop_second;
  logic [3:0]  rd_out;
  logic [13:0] imm_out;
  logic        fetch_hold;
  logic        odd_rd_exc;
  logic        imm_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ldw_sdw_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .rd_in(rd_in), .imm_in(imm_in), .stall_in(stall_in), .flush_in(flush_in),
    .uop_valid(uop_valid), .uop_second(uop_second), .rd_out(rd_out),
    .imm_out(imm_out), .fetch_hold(fetch_hold), .odd_rd_exc(odd_rd_exc),
    .imm_wrap(imm_wrap)
  );

  // flags = {uop_valid, uop_second, fetch_hold, odd_rd_exc, imm_wrap}
  typedef struct {
    logic        rst;
    logic        iv;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [13:0] imm;
    logic        stall;
    logic        flush;
    logic [4:0]  flags;
    logic [3:0]  exp_rd;
    logic [13:0] exp_imm;
  } vec_t;

  localparam logic [5:0] LDW = 6'b000110;
  localparam logic [5:0] SDW = 6'b000111;
  localparam logic [5:0] ADD = 6'b000001;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic iv, logic [5:0] op, logic [3:0] rd, logic [13:0] imm,
                             logic stall, logic flush, logic [4:0] flags, logic [3:0] erd, logic [13:0] eimm);
    vec_t t;
    t.rst = rst; t.iv = iv; t.op = op; t.rd = rd; t.imm = imm; t.stall = stall; t.flush = flush;
    t.flags = flags; t.exp_rd = erd; t.exp_imm = eimm;
    return t;
  endfunction

  function automatic logic [22:0] actual();
    return {uop_valid, uop_second, fetch_hold, odd_rd_exc, imm_wrap, rd_out, imm_out};
  endfunction

  task automatic drive(input logic rst, input logic iv, input logic [5:0] op, input logic [3:0] rd,
                       input logic [13:0] imm, input logic stall, input logic flush);
    reset = rst; instr_valid = iv; opcode = op; rd_in = rd; imm_in = imm;
    stall_in = stall; flush_in = flush;
  endtask

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {v,s,h,x,w}=%b rd=%0d imm=0x%h, want {v,s,h,x,w}=%b rd=%0d imm=0x%h",
               name, act[22:18], act[17:14], act[13:0], exp[22:18], exp[17:14], exp[13:0]);
    end
  endtask

  // Reference model: a pending second word described by its register, immediate and wrap flag
  bit pending;
  int p_rd, p_imm;
  bit p_wrap;
  bit exc_seen;

  function automatic logic [22:0] model_out(logic rst, logic iv, logic [5:0] op, logic [3:0] rd,
                                            logic [13:0] imm, logic flush);
    bit uv, sec, hold, exc, wrap;
    int ord, oimm;
    bit paired;
    uv = 0; sec = 0; hold = 0; exc = 0; wrap = 0; ord = 0; oimm = 0;
    if (!rst) begin
      if (pending) begin
        uv = !flush; sec = !flush; wrap = p_wrap && !flush; ord = p_rd; oimm = p_imm;
      end else begin
        paired = iv && (op == LDW || op == SDW);
        ord = rd; oimm = imm;
        if (!flush) begin
          if (!paired) uv = iv;
          else if (rd % 2 == 1) exc = !exc_seen;
          else begin uv = 1; hold = 1; end
        end
      end
    end
    return {uv, sec, hold, exc, wrap, 4'(ord), 14'(oimm)};
  endfunction

  task automatic model_edge(logic rst, logic iv, logic [5:0] op, logic [3:0] rd, logic [13:0] imm,
                            logic stall, logic flush, logic exc_out);
    bit paired;
    paired = iv && (op == LDW || op == SDW);
    if (rst) begin
      pending = 0; p_rd = 0; p_imm = 0; p_wrap = 0; exc_seen = 0;
    end else if (flush) begin
      pending = 0; exc_seen = 0;
    end else if (stall) begin
      if (exc_out) exc_seen = 1;
    end else begin
      exc_seen = 0;
      if (pending) pending = 0;
      else if (paired && rd % 2 == 0) begin
        pending = 1;
        p_rd    = rd + 1;
        p_imm   = (int'(imm) + 4) % 16384;
        p_wrap  = (int'(imm) + 4) >= 16384;
      end
    end
  endtask

  initial begin
    logic [22:0] exp;
    logic r, iv, st, fl;
    logic [5:0] op;
    logic [3:0] rd;
    logic [13:0] imm;

    //          rst iv op   rd  imm       stl fl  {v s h x w} rd  imm
    tbl.push_back(v(1, 1, ADD,  5, 14'h0123, 0, 0, 5'b00000,  0, 14'h0000));
    tbl.push_back(v(0, 1, LDW,  4, 14'h0010, 0, 0, 5'b10100,  4, 14'h0010));
    tbl.push_back(v(0, 1, LDW,  4, 14'h0010, 0, 0, 5'b11000,  5, 14'h0014));
    tbl.push_back(v(0, 1, SDW,  2, 14'h3FFE, 0, 0, 5'b10100,  2, 14'h3FFE));
    tbl.push_back(v(0, 1, SDW,  2, 14'h3FFE, 0, 0, 5'b11001,  3, 14'h0002));
    tbl.push_back(v(0, 1, LDW,  3, 14'h0020, 0, 0, 5'b00010,  3, 14'h0020));
    tbl.push_back(v(0, 1, ADD,  3, 14'h0020, 0, 0, 5'b10000,  3, 14'h0020));
    tbl.push_back(v(0, 1, LDW,  6, 14'h0100, 0, 0, 5'b10100,  6, 14'h0100));
    tbl.push_back(v(0, 1, LDW,  6, 14'h0100, 1, 0, 5'b11000,  7, 14'h0104));
    tbl.push_back(v(0, 1, LDW,  6, 14'h0100, 1, 0, 5'b11000,  7, 14'h0104));
    tbl.push_back(v(0, 1, LDW,  6, 14'h0100, 1, 0, 5'b11000,  7, 14'h0104));
    tbl.push_back(v(0, 1, LDW,  6, 14'h0100, 0, 0, 5'b11000,  7, 14'h0104));
    tbl.push_back(v(0, 1, ADD,  1, 14'h0005, 0, 0, 5'b10000,  1, 14'h0005));
    tbl.push_back(v(0, 1, LDW,  8, 14'h0040, 0, 0, 5'b10100,  8, 14'h0040));
    tbl.push_back(v(0, 1, LDW,  8, 14'h0040, 1, 1, 5'b00000,  9, 14'h0044));
    tbl.push_back(v(0, 1, ADD,  2, 14'h0007, 0, 0, 5'b10000,  2, 14'h0007));
    tbl.push_back(v(0, 0, LDW,  4, 14'h0010, 0, 0, 5'b00000,  4, 14'h0010));
    tbl.push_back(v(0, 1, LDW,  4, 14'h0010, 0, 1, 5'b00000,  4, 14'h0010));
    tbl.push_back(v(0, 0, ADD,  0, 14'h0000, 0, 0, 5'b00000,  0, 14'h0000));
    tbl.push_back(v(0, 1, LDW, 10, 14'h3FFC, 0, 0, 5'b10100, 10, 14'h3FFC));
    tbl.push_back(v(1, 1, LDW, 10, 14'h3FFC, 0, 0, 5'b00000,  0, 14'h0000));
    tbl.push_back(v(0, 0, ADD,  0, 14'h0000, 0, 0, 5'b00000,  0, 14'h0000));
    tbl.push_back(v(0, 1, LDW,  5, 14'h0030, 1, 0, 5'b00010,  5, 14'h0030));
    tbl.push_back(v(0, 1, LDW,  5, 14'h0030, 1, 0, 5'b00000,  5, 14'h0030));
    tbl.push_back(v(0, 1, LDW,  5, 14'h0030, 0, 0, 5'b00000,  5, 14'h0030));
    tbl.push_back(v(0, 0, ADD,  0, 14'h0000, 0, 0, 5'b00000,  0, 14'h0000));

    drive(1, 0, ADD, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].op, tbl[i].rd, tbl[i].imm, tbl[i].stall, tbl[i].flush);
      @(negedge clk);
      check($sformatf("vec%0d", i), {tbl[i].flags, tbl[i].exp_rd, tbl[i].exp_imm});
      @(posedge clk); #1;
    end

    // Hand-written: reset mid-SECOND, then held decode must not produce an orphan second word
    drive(0, 1, SDW, 12, 14'h0008, 0, 0);
    @(negedge clk); check("mid_first", {5'b10100, 4'd12, 14'h0008});
    @(posedge clk); #1;
    drive(1, 1, SDW, 12, 14'h0008, 0, 0);
    #1 check("mid_reset_async", 23'd0);
    @(posedge clk); #1;
    drive(0, 0, SDW, 12, 14'h0008, 0, 0);
    @(negedge clk); check("mid_after_reset", {5'b00000, 4'd12, 14'h0008});
    @(posedge clk); #1;

    // Randomized run against the reference model, starting from reset
    pending = 0; p_rd = 0; p_imm = 0; p_wrap = 0; exc_seen = 0;
    for (int c = 0; c < 600; c++) begin
      r  = (c == 0) || ($urandom_range(0, 99) < 3);
      iv = $urandom_range(0, 99) < 85;
      case ($urandom_range(0, 4))
        0: op = LDW;
        1: op = SDW;
        default: op = 6'($urandom);
      endcase
      rd  = 4'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 14'(16380 + $urandom_range(0, 3)) : 14'($urandom);
      st  = $urandom_range(0, 99) < 20;
      fl  = $urandom_range(0, 99) < 8;
      drive(r, iv, op, rd, imm, st, fl);
      exp = model_out(r, iv, op, rd, imm, fl);
      @(negedge clk);
      check($sformatf("rand%0d", c), exp);
      @(posedge clk);
      model_edge(r, iv, op, rd, imm, st, fl, exp[19]);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
